axi4_cmd_master: RTL
====================

# axi4_cmd_master

Single-outstanding AXI4 master that converts a simple valid/ready register command stream into single-beat AXI4 write (AW/W/B) or read (AR/R) transactions. It sits directly upstream of the AXI4 register/memory slave on the system `axi4_if` master side, replacing bench-driven channel wiggling with a synthesizable initiator. The block returns one response (read data plus RESP code) per command.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; must be 32 or 64
- `TIMEOUT_CYC`, 256, wait-state watchdog limit; used only under the config macro
- `clk` input 1, single clock, rising edge
- `reset` input 1, synchronous, active-low; sampled on the rising edge of `clk`
- `cmd_valid`/`cmd_ready` in/out 1, command handshake
- `cmd_write` input 1, 1 = write, 0 = read
- `cmd_addr` input ADDR_W, byte address
- `cmd_wdata`/`cmd_wstrb` input DATA_W / DATA_W/8, write payload; ignored for reads
- `rsp_valid`/`rsp_ready` out/in 1, response handshake
- `rsp_rdata` output DATA_W, read data; 0 for writes
- `rsp_resp` output 2, AXI RESP code (BRESP or RRESP)
- `rsp_timeout` output 1, response produced by the watchdog
- `awaddr`,`awvalid`/`awready`; `araddr`,`arvalid`/`arready`: AXI address channels, ADDR_W plus 1-bit handshakes
- `awlen`,`arlen` output 8, constant 0; `awsize`,`arsize` output 3, constant log2(DATA_W/8); `awburst`,`arburst` output 2, constant 2'b01 (INCR)
- `wdata`,`wstrb`,`wlast`,`wvalid`/`wready`: W channel; `wlast` is 1 whenever `wvalid` is 1
- `bresp`,`bvalid`/`bready`: B channel; `rdata`,`rresp`,`rlast`,`rvalid`/`rready`: R channel

## Operation
- States: IDLE, WR (AW and W pending), WR_B, RD_A, RD_R, RSP.
- IDLE: `cmd_ready`=1. When `cmd_valid` is high, the command is latched; the FSM moves to WR or RD_A.
- Address alignment: the latched address has its low log2(DATA_W/8) bits cleared before it drives `awaddr`/`araddr`.
- WR: `awvalid` and `wvalid` assert together. Each one drops on the cycle after its own handshake, tracked by `aw_done`/`w_done` flags. The handshakes may complete in either order or in the same cycle. When both are done, the FSM moves to WR_B.
- WR_B: `bready`=1. On the `bvalid` handshake, `bresp` is captured and the FSM moves to RSP.
- RD_A: `arvalid`=1 until the handshake completes, then RD_R.
- RD_R: `rready`=1. On the `rvalid` handshake, `rdata`/`rresp` are captured and the FSM moves to RSP.
  - The block does not check `rlast`.
  - A `bvalid` or `rvalid` that arrives in a state not waiting for it is not accepted; `bready`/`rready` stay 0 outside WR_B/RD_R.
- RSP: `rsp_valid`=1, and the response is held stable until `rsp_ready` is high. The FSM then returns to IDLE.
- `cmd_ready`=0 in every state except IDLE, so at most one transaction is outstanding.
- Reset (`reset`=0) at any time takes effect on the next edge:
  - FSM returns to IDLE.
  - All valids and readies are 0, except `cmd_ready`=1.
  - Captured registers, `rsp_*`, `awaddr`/`araddr`, `wdata`, `wstrb` are all 0.
  - Any in-flight transaction is abandoned.

## Timing
- Every output is registered; the constant outputs are the only exception.
- A command accepted at edge N asserts AXI valids at N+1.
- Write with zero-wait slave: AW/W handshake at N+1; `bready` at N+2. With `bvalid` also at N+2, `rsp_valid` asserts at N+3.
- Read with zero-wait slave: AR handshake at N+1; with `rvalid` at N+2, `rsp_valid` asserts at N+3.
- If `rsp_ready` is high in the same cycle `rsp_valid` rises, the next `cmd_ready` is at N+4.
- Throughput is therefore one command per 4 cycles minimum.

## Configuration
- Macro: `AXI4_CMD_MASTER_TIMEOUT_EN`.
- Defined:
  - A counter clears on every state entry and increments in WR, WR_B, RD_A and RD_R.
  - On reaching TIMEOUT_CYC, all AXI valids and readies drop and the FSM goes to RSP with `rsp_resp`=2'b10, `rsp_rdata`=0 and `rsp_timeout`=1.
  - This is a recovery path; the AXI protocol violation is accepted.
- Undefined: no counter; the block waits indefinitely, and `rsp_timeout` is tied to 0.

## Structure
- The shared package `axi4_pkg` holds:
  - the state enum `cmd_mst_state_e`
  - the RESP constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11
  - the burst constant `BURST_INCR`
- A single module with no sub-module. The watchdog counter is inline and wrapped in the macro guard.

## Test plan
- Write to address 0x04 with data 0xDEADBEEF and strobe 0xF, zero-wait slave -> AW/W issued at N+1 with `awaddr`=0x04, `wlast`=1; `rsp_valid` at N+3 with `rsp_resp`=0.
- Read back 0x04 -> `araddr`=0x04; `rsp_rdata`=0xDEADBEEF, `rsp_resp`=0, `rsp_timeout`=0.
- Address 0x07 write -> `awaddr`=0x04. Separately, `wready` held low 3 cycles after `awready` -> `awvalid` drops first, `wvalid` stays high until the handshake, and exactly one response is returned.
- Slave returns `rresp`=2'b11 and `rsp_ready` is held low 5 cycles -> `rsp_valid`, `rsp_resp`=3 and `rsp_rdata` stay stable, and `cmd_ready` stays 0 throughout.
- `reset` pulled low while in WR_B -> next edge: all AXI valids/readies are 0, `cmd_ready`=1, `rsp_valid`=0.
- With `AXI4_CMD_MASTER_TIMEOUT_EN` and TIMEOUT_CYC=16, `arready` never asserted -> after 16 cycles in RD_A, `rsp_valid`=1, `rsp_resp`=2'b10, `rsp_timeout`=1, `arvalid`=0.

Source files
------------

// File: rtl/axi4_pkg.sv
// Shared AXI4 definitions for the command master: FSM state encoding,
// RESP codes, burst type and a helper that derives AxSIZE from the data width.
package axi4_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_WR_B = 3'd2,
        ST_RD_A = 3'd3,
        ST_RD_R = 3'd4,
        ST_RSP  = 3'd5
    } cmd_mst_state_e;

    localparam logic [1:0] OKAY       = 2'b00;
    localparam logic [1:0] EXOKAY     = 2'b01;
    localparam logic [1:0] SLVERR     = 2'b10;
    localparam logic [1:0] DECERR     = 2'b11;
    localparam logic [1:0] BURST_INCR = 2'b01;

    // AxSIZE is log2 of the bytes per beat; only 32- and 64-bit buses exist here.
    function automatic logic [2:0] axi_size(input int data_w);
        return (data_w == 64) ? 3'd3 : 3'd2;
    endfunction

endpackage

// File: rtl/axi4_cmd_master.sv
// Single-outstanding AXI4 master: one valid/ready command becomes one
// single-beat AXI4 write or read, and one response is returned per command.
// Optional wait-state watchdog: define AXI4_CMD_MASTER_TIMEOUT_EN.
module axi4_cmd_master
    import axi4_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,
    output logic                rsp_timeout,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready,
    output logic [ADDR_W-1:0]   araddr,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready
);

    localparam int ALIGN_LSB = (DATA_W == 64) ? 3 : 2;
    localparam int STRB_W    = DATA_W / 8;

    cmd_mst_state_e      state_q, state_d;
    logic                cmd_ready_q, rsp_valid_q;
    logic                awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q;
    logic                aw_done_q, w_done_q;
    logic [ADDR_W-1:0]   awaddr_q, araddr_q;
    logic [DATA_W-1:0]   wdata_q, rsp_rdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic [1:0]          rsp_resp_q;

    logic [ADDR_W-1:0]   aligned_addr_s;
    logic                aw_all_s, w_all_s, b_hs_s, r_hs_s;
    logic                tmo_hit_s, tmo_fire_s;
    logic                unused_rlast_s;

    assign aligned_addr_s = {cmd_addr[ADDR_W-1:ALIGN_LSB], {ALIGN_LSB{1'b0}}};
    assign aw_all_s       = aw_done_q | (awvalid_q & awready);
    assign w_all_s        = w_done_q  | (wvalid_q  & wready);
    assign b_hs_s         = (state_q == ST_WR_B) & bvalid;
    assign r_hs_s         = (state_q == ST_RD_R) & rvalid;
    assign unused_rlast_s = rlast;

`ifdef AXI4_CMD_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_q;
    logic             waiting_s;
    logic             rsp_timeout_q;

    assign waiting_s = (state_q == ST_WR) || (state_q == ST_WR_B) ||
                       (state_q == ST_RD_A) || (state_q == ST_RD_R);
    assign tmo_hit_s = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    // Wait-state watchdog: restarts on every state change, counts while waiting on the slave.
    always_ff @(posedge clk) begin
        if (!reset || (state_d != state_q)) begin
            tmo_q <= {TMO_W{1'b0}};
        end else if (waiting_s) begin
            tmo_q <= tmo_q + TMO_W'(1);
        end else begin
            tmo_q <= tmo_q;
        end
    end

    // Flags responses that were manufactured by the watchdog rather than the slave.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rsp_timeout_q <= 1'b0;
        end else if (tmo_fire_s) begin
            rsp_timeout_q <= 1'b1;
        end else if (b_hs_s || r_hs_s) begin
            rsp_timeout_q <= 1'b0;
        end else begin
            rsp_timeout_q <= rsp_timeout_q;
        end
    end

    assign rsp_timeout = rsp_timeout_q;
`else
    localparam int unused_tmo_cyc = TIMEOUT_CYC;
    assign tmo_hit_s   = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    // Next-state decode; handshake completion always wins over a watchdog expiry.
    always_comb begin
        state_d    = state_q;
        tmo_fire_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) state_d = cmd_write ? ST_WR : ST_RD_A;
                else           state_d = ST_IDLE;
            end
            ST_WR: begin
                if (aw_all_s && w_all_s) begin
                    state_d = ST_WR_B;
                end else if (tmo_hit_s) begin
                    state_d    = ST_RSP;
                    tmo_fire_s = 1'b1;
                end else begin
                    state_d = ST_WR;
                end
            end
            ST_WR_B: begin
                if (bvalid) begin
                    state_d = ST_RSP;
                end else if (tmo_hit_s) begin
                    state_d    = ST_RSP;
                    tmo_fire_s = 1'b1;
                end else begin
                    state_d = ST_WR_B;
                end
            end
            ST_RD_A: begin
                if (arvalid_q && arready) begin
                    state_d = ST_RD_R;
                end else if (tmo_hit_s) begin
                    state_d    = ST_RSP;
                    tmo_fire_s = 1'b1;
                end else begin
                    state_d = ST_RD_A;
                end
            end
            ST_RD_R: begin
                if (rvalid) begin
                    state_d = ST_RSP;
                end else if (tmo_hit_s) begin
                    state_d    = ST_RSP;
                    tmo_fire_s = 1'b1;
                end else begin
                    state_d = ST_RD_R;
                end
            end
            ST_RSP: begin
                if (rsp_ready) state_d = ST_IDLE;
                else           state_d = ST_RSP;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM register plus all handshake outputs, derived from the state being entered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            awaddr_q    <= {ADDR_W{1'b0}};
            araddr_q    <= {ADDR_W{1'b0}};
            wdata_q     <= {DATA_W{1'b0}};
            wstrb_q     <= {STRB_W{1'b0}};
            rsp_rdata_q <= {DATA_W{1'b0}};
            rsp_resp_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= (state_d == ST_IDLE);
            rsp_valid_q <= (state_d == ST_RSP);
            bready_q    <= (state_d == ST_WR_B);
            arvalid_q   <= (state_d == ST_RD_A);
            rready_q    <= (state_d == ST_RD_R);
            // AW and W retire independently; each valid drops after its own handshake.
            awvalid_q   <= (state_d == ST_WR) && !((state_q == ST_WR) && aw_all_s);
            wvalid_q    <= (state_d == ST_WR) && !((state_q == ST_WR) && w_all_s);
            aw_done_q   <= (state_q == ST_WR) && (state_d == ST_WR) && aw_all_s;
            w_done_q    <= (state_q == ST_WR) && (state_d == ST_WR) && w_all_s;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid && cmd_write) begin
                        awaddr_q <= aligned_addr_s;
                        wdata_q  <= cmd_wdata;
                        wstrb_q  <= cmd_wstrb;
                    end else if (cmd_valid) begin
                        araddr_q <= aligned_addr_s;
                    end
                end
                ST_WR_B: begin
                    if (bvalid) begin
                        rsp_resp_q  <= bresp;
                        rsp_rdata_q <= {DATA_W{1'b0}};
                    end
                end
                ST_RD_R: begin
                    if (rvalid) begin
                        rsp_resp_q  <= rresp;
                        rsp_rdata_q <= rdata;
                    end
                end
                default: begin
                end
            endcase
            if (tmo_fire_s) begin
                rsp_resp_q  <= SLVERR;
                rsp_rdata_q <= {DATA_W{1'b0}};
            end
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;
    assign awaddr    = awaddr_q;
    assign awvalid   = awvalid_q;
    assign wdata     = wdata_q;
    assign wstrb     = wstrb_q;
    assign wlast     = wvalid_q;
    assign wvalid    = wvalid_q;
    assign bready    = bready_q;
    assign araddr    = araddr_q;
    assign arvalid   = arvalid_q;
    assign rready    = rready_q;
    assign awlen     = 8'd0;
    assign arlen     = 8'd0;
    assign awsize    = axi_size(DATA_W);
    assign arsize    = axi_size(DATA_W);
    assign awburst   = BURST_INCR;
    assign arburst   = BURST_INCR;

endmodule
